// File: rtl/line_stream_ctrl_if.sv
// line_stream_ctrl_if: command, word-stream and line-memory signals of the line stream controller.
interface line_stream_ctrl_if #(
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 16,
   parameter int ADDR_W     = 9
);
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic                         cmd_write;
   logic [4:0]                   cmd_line;
   logic [5:0]                   cmd_lines;
   logic [WORD_W-1:0]            wr_data;
   logic                         wr_valid;
   logic                         wr_ready;
   logic [WORD_W-1:0]            rd_data;
   logic                         rd_valid;
   logic                         rd_ready;
   logic                         rd_last;
   logic                         mem_write;
   logic                         mem_read;
   logic [ADDR_W-1:0]            mem_address;
   logic [WORD_W*LINE_WORDS-1:0] mem_in_data;
   logic [WORD_W*LINE_WORDS-1:0] mem_out_data;
   logic                         busy;
   logic                         done;

   modport master (
      input  cmd_valid, cmd_write, cmd_line, cmd_lines, wr_data, wr_valid, rd_ready, mem_out_data,
      output cmd_ready, wr_ready, rd_data, rd_valid, rd_last, mem_write, mem_read, mem_address,
             mem_in_data, busy, done
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_line, cmd_lines, wr_data, wr_valid, rd_ready, mem_out_data,
      input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last, mem_write, mem_read, mem_address,
             mem_in_data, busy, done
   );
endinterface

// File: rtl/line_stream_ctrl.sv
// line_stream_ctrl: packs a word stream into 16-word lines for the line memory and replays fetched lines as a word stream.
module line_stream_ctrl (
   input logic                clk,
   input logic                rst,
   line_stream_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, FILL, WRITE, FETCH, DRAIN} state_t;

   state_t       r_state;
   logic [3:0]   r_k;
   logic [4:0]   r_line;
   logic [5:0]   r_left;
   logic [511:0] r_buf;
   logic         r_done;
   logic         r_zero;
   logic         r_mem_write;
   logic         r_mem_read;
   logic [8:0]   r_mem_addr;
   logic [8:0]   w_idx;
   logic         w_final;

   // word k lives at bits [511-32k -: 32], i.e. base offset (15-k)*32
   assign w_idx   = {~r_k, 5'd0};
   assign w_final = (r_left == 6'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_line      <= '0;
         r_left      <= '0;
         r_buf       <= '0;
         r_done      <= 1'b0;
         r_zero      <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_addr  <= '0;
      end else begin
         r_done      <= 1'b0;
         r_zero      <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_addr  <= '0;
         case (r_state)
            IDLE: if (bus.cmd_valid) begin
               r_line <= bus.cmd_line;
               r_left <= bus.cmd_lines;
               r_k    <= '0;
               if (bus.cmd_lines == 6'd0) begin
                  r_done <= 1'b1;
                  r_zero <= 1'b1;
               end else if (bus.cmd_write) begin
                  r_state <= FILL;
               end else begin
                  r_state    <= FETCH;
                  r_mem_read <= 1'b1;
                  r_mem_addr <= {bus.cmd_line, 4'd0};
               end
            end
            FILL: if (bus.wr_valid) begin
               r_buf[w_idx +: 32] <= bus.wr_data;
               r_k                <= r_k + 4'd1;
               if (r_k == 4'd15) begin
                  r_state     <= WRITE;
                  r_mem_write <= 1'b1;
                  r_mem_addr  <= {r_line, 4'd0};
               end
            end
            WRITE: begin
               r_line  <= r_line + 5'd1;
               r_left  <= r_left - 6'd1;
               r_done  <= w_final;
               r_state <= w_final ? IDLE : FILL;
            end
            FETCH: begin
               r_buf   <= bus.mem_out_data;
               r_k     <= '0;
               r_state <= DRAIN;
            end
            DRAIN: if (bus.rd_ready) begin
               r_k <= r_k + 4'd1;
               if (r_k == 4'd15) begin
                  r_line     <= r_line + 5'd1;
                  r_left     <= r_left - 6'd1;
                  r_done     <= w_final;
                  r_state    <= w_final ? IDLE : FETCH;
                  r_mem_read <= !w_final;
                  r_mem_addr <= w_final ? 9'd0 : {r_line + 5'd1, 4'd0};
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = (r_state == IDLE);
   assign bus.busy        = (r_state != IDLE) || r_zero;
   assign bus.wr_ready    = (r_state == FILL);
   assign bus.rd_valid    = (r_state == DRAIN);
   assign bus.rd_data     = r_buf[w_idx +: 32];
   assign bus.rd_last     = (r_state == DRAIN) && (r_k == 4'd15) && w_final;
   assign bus.mem_write   = r_mem_write;
   assign bus.mem_read    = r_mem_read;
   assign bus.mem_address = r_mem_addr;
   assign bus.mem_in_data = r_buf;
   assign bus.done        = r_done;
endmodule

// File: tb/tb_line_stream_ctrl.sv
// tb_line_stream_ctrl: directed tests with a word-level memory/stream model and a per-cycle output monitor.
module tb_line_stream_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   line_stream_ctrl_if bus ();
   line_stream_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0]  mem     [512];
   logic [31:0]  ref_mem [512];
   logic         mem_init;
   logic [511:0] mdata;

   always_comb begin
      mdata = '0;
      for (int k = 0; k < 16; k++) mdata[511-32*k -: 32] = mem[{bus.mem_address[8:4], k[3:0]}];
   end
   assign bus.mem_out_data = mdata;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 + i;
      end else if (bus.mem_write) begin
         for (int k = 0; k < 16; k++) mem[bus.mem_address + 9'(k)] <= bus.mem_in_data[511-32*k -: 32];
      end
   end

   int errors = 0, checks = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic [8:0]   exp_w_addr [$];
   logic [511:0] exp_w_data [$];
   logic [8:0]   exp_r_addr [$];
   logic [31:0]  exp_rd     [$];
   logic         exp_last   [$];
   logic [8:0]   w_addrs    [$];
   int wcnt = 0, rcnt = 0, done_cnt = 0, done_cyc = 0, w_cyc = 0, rv_cyc = 0, busy_cnt = 0, rd_n = 0, last_cnt = 0;
   logic [31:0]  rd_sum = '0;
   logic [511:0] last_w_data = '0;
   logic [8:0]   last_r_addr = '0;
   logic         stall_prev = 1'b0, rv_prev = 1'b0;
   logic [31:0]  hold = '0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         stall_prev = 1'b0;
         rv_prev    = 1'b0;
      end else begin
         chk("strobes_exclusive", bus.mem_write & bus.mem_read, 0);
         if (!bus.mem_write && !bus.mem_read) chk("idle_address", bus.mem_address, 0);
         if (bus.mem_write) begin
            wcnt++;
            w_cyc = cyc;
            w_addrs.push_back(bus.mem_address);
            last_w_data = bus.mem_in_data;
            if (exp_w_addr.size() == 0) chk("write_expected", 0, 1);
            else begin
               chk("write_address", bus.mem_address, exp_w_addr.pop_front());
               chk("write_line", bus.mem_in_data, exp_w_data.pop_front());
            end
         end
         if (bus.mem_read) begin
            rcnt++;
            last_r_addr = bus.mem_address;
            if (exp_r_addr.size() == 0) chk("read_expected", 0, 1);
            else chk("read_address", bus.mem_address, exp_r_addr.pop_front());
         end
         if (bus.rd_valid && !rv_prev) rv_cyc = cyc;
         if (stall_prev && bus.rd_valid) chk("rd_hold", bus.rd_data, hold);
         if (bus.rd_valid && bus.rd_ready) begin
            rd_n++;
            rd_sum += bus.rd_data;
            if (bus.rd_last) last_cnt++;
            if (exp_rd.size() == 0) chk("rd_expected", 0, 1);
            else begin
               chk("rd_data", bus.rd_data, exp_rd.pop_front());
               chk("rd_last", bus.rd_last, exp_last.pop_front());
            end
         end
         if (!bus.rd_valid) chk("rd_last_idle", bus.rd_last, 0);
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.busy) busy_cnt++;
         stall_prev = bus.rd_valid && !bus.rd_ready;
         hold       = bus.rd_data;
         rv_prev    = bus.rd_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string t);
      chk({t, "_cmd_ready"}, bus.cmd_ready, 1);
      chk({t, "_busy"}, bus.busy, 0);
      chk({t, "_done"}, bus.done, 0);
      chk({t, "_wr_ready"}, bus.wr_ready, 0);
      chk({t, "_rd_valid"}, bus.rd_valid, 0);
      chk({t, "_rd_last"}, bus.rd_last, 0);
      chk({t, "_rd_data"}, bus.rd_data, 0);
      chk({t, "_mem_write"}, bus.mem_write, 0);
      chk({t, "_mem_read"}, bus.mem_read, 0);
      chk({t, "_mem_address"}, bus.mem_address, 0);
      chk({t, "_mem_in_data"}, bus.mem_in_data, 0);
   endtask

   task automatic do_cmd(input logic w, input logic [4:0] l, input logic [5:0] n, output int acc);
      int g = 0;
      while (!bus.cmd_ready && g < 100) begin tick(); g++; end
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_line  = l;
      bus.cmd_lines = n;
      tick();
      bus.cmd_valid = 1'b0;
      acc = cyc - 1;
   endtask

   task automatic wait_done(output int dc);
      int g = 0;
      while (!bus.done && g < 3000) begin tick(); g++; end
      chk("done_seen", bus.done, 1);
      dc = cyc;
   endtask

   task automatic write_cmd(input logic [4:0] l, input int n, input logic [31:0] base, input bit stall,
                            output int fill0, output int dc);
      int acc, g, ln;
      logic [511:0] lb;
      do_cmd(1'b1, l, 6'(n), acc);
      fill0 = acc + 1;
      lb = '0;
      for (int j = 0; j < 16 * n; j++) begin
         if (stall && j % 5 == 2) begin bus.wr_valid = 1'b0; tick(); end
         bus.wr_valid = 1'b1;
         bus.wr_data  = base + j;
         g = 0;
         while (!bus.wr_ready && g < 100) begin tick(); g++; end
         tick();
         lb[511-32*(j%16) -: 32] = base + j;
         if (j % 16 == 15) begin
            ln = (l + j / 16) % 32;
            exp_w_addr.push_back(9'(ln * 16));
            exp_w_data.push_back(lb);
            for (int k = 0; k < 16; k++) ref_mem[ln*16+k] = base + (j - 15 + k);
         end
      end
      bus.wr_valid = 1'b0;
      wait_done(dc);
   endtask

   task automatic read_cmd(input logic [4:0] l, input int n, input bit toggle, output int acc, output int dc);
      int g = 0, ln;
      for (int i = 0; i < n; i++) begin
         ln = (l + i) % 32;
         exp_r_addr.push_back(9'(ln * 16));
         for (int k = 0; k < 16; k++) begin
            exp_rd.push_back(ref_mem[ln*16+k]);
            exp_last.push_back(i == n - 1 && k == 15);
         end
      end
      bus.rd_ready = 1'b1;
      do_cmd(1'b0, l, 6'(n), acc);
      while (!bus.done && g < 3000) begin
         if (toggle) bus.rd_ready = ~bus.rd_ready;
         tick();
         g++;
      end
      chk("read_done_seen", bus.done, 1);
      dc = cyc;
      bus.rd_ready = 1'b1;
   endtask

   initial begin
      int acc, acc2, f0, dc, s0, r0, n0, l0, d0, b0, q0;
      logic [31:0] sum0;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_line = '0; bus.cmd_lines = '0;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
      mem_init = 1'b1;
      for (int i = 0; i < 512; i++) ref_mem[i] = 32'hA500_0000 + i;
      tick(); tick(); tick();
      check_idle("reset");
      mem_init = 1'b0;
      rst = 1'b0;
      tick();

      // reset during FILL at k=7 discards the partial line
      do_cmd(1'b1, 5'd5, 6'd1, acc);
      for (int j = 0; j < 7; j++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 32'hBAD0 + j;
         tick();
      end
      bus.wr_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check_idle("midfill_reset");
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      chk("no_write_after_reset", wcnt, 0);
      sum0 = rd_sum;
      read_cmd(5'd5, 1, 1'b0, acc, dc);
      tick();
      chk("prior_contents_sum", rd_sum - sum0, 32'h5000_0578);

      // single-line write
      s0 = wcnt;
      write_cmd(5'd2, 1, 32'h100, 1'b0, f0, dc);
      chk("wr1_count", wcnt - s0, 1);
      chk("wr1_delay", w_cyc - f0, 16);
      chk("wr1_address", w_addrs[w_addrs.size()-1], 32);
      chk("wr1_word0", last_w_data[511:480], 32'h100);
      chk("wr1_word15", last_w_data[31:0], 32'h10F);
      chk("wr1_done", dc, w_cyc + 1);

      // read-back with rd_ready toggling
      r0 = rcnt; n0 = rd_n; sum0 = rd_sum; l0 = last_cnt;
      read_cmd(5'd2, 1, 1'b1, acc, dc);
      tick();
      chk("rb_reads", rcnt - r0, 1);
      chk("rb_address", last_r_addr, 32);
      chk("rb_first_valid", rv_cyc, acc + 2);
      chk("rb_words", rd_n - n0, 16);
      chk("rb_sum", rd_sum - sum0, 32'h1078);
      chk("rb_last_count", last_cnt - l0, 1);

      // wrap-around burst with input stalls, then read it back
      q0 = w_addrs.size(); d0 = done_cnt;
      write_cmd(5'd31, 2, 32'h3100, 1'b1, f0, dc);
      tick();
      chk("wrap_addr0", w_addrs[q0], 496);
      chk("wrap_addr1", w_addrs[q0+1], 0);
      chk("wrap_done_once", done_cnt - d0, 1);
      read_cmd(5'd31, 2, 1'b0, acc, dc);
      tick();

      // zero-length commands back to back
      s0 = wcnt; r0 = rcnt; b0 = busy_cnt; d0 = done_cnt;
      do_cmd(1'b1, 5'd7, 6'd0, acc);
      chk("zero_done_now", bus.done, 1);
      do_cmd(1'b0, 5'd3, 6'd0, acc2);
      tick(); tick(); tick();
      chk("zero_b2b_accept", acc2, acc + 1);
      chk("zero_writes", wcnt - s0, 0);
      chk("zero_reads", rcnt - r0, 0);
      chk("zero_busy_cycles", busy_cnt - b0, 2);
      chk("zero_done_count", done_cnt - d0, 2);
      chk("zero_done_cycle", done_cyc, acc2 + 1);

      // full-memory burst
      write_cmd(5'd0, 32, 32'd0, 1'b0, f0, dc);
      chk("full_write_cycles", dc - f0, 544);
      r0 = rcnt; n0 = rd_n; sum0 = rd_sum; l0 = last_cnt;
      read_cmd(5'd0, 32, 1'b0, acc, dc);
      tick();
      chk("full_reads", rcnt - r0, 32);
      chk("full_read_cycles", dc - acc, 545);
      chk("full_words", rd_n - n0, 512);
      chk("full_sum", rd_sum - sum0, 32'd130816);
      chk("full_last_count", last_cnt - l0, 1);

      tick();
      chk("pending_writes", exp_w_addr.size(), 0);
      chk("pending_reads", exp_r_addr.size(), 0);
      chk("pending_words", exp_rd.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
